// File: rtl/sim_axis_throttled_sink.sv
// Verification-only AXI-Stream sink. It applies LFSR-paced back-pressure and checks that the
// received data follows an incrementing pattern, reporting beat/error counts and the first error.
module sim_axis_throttled_sink #(
    parameter int unsigned           DATA_WIDTH       = 32,
    parameter int unsigned           MAX_STALL_CYCLES = 6,
    parameter logic [15:0]           LFSR_SEED        = 16'hACE1,
    parameter logic [DATA_WIDTH-1:0] START_VALUE      = '0,
    parameter int unsigned           EXPECTED_BEATS   = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] axis_s_tdata,
    input  logic                  axis_s_tvalid,
    output logic                  axis_s_tready,
    input  logic                  enable_i,
    output logic [31:0]           beat_count_o,
    output logic [15:0]           error_count_o,
    output logic                  error_o,
    output logic [DATA_WIDTH-1:0] first_err_data_o,
    output logic [31:0]           first_err_index_o,
    output logic                  done_o
);

    localparam int unsigned SW        = (MAX_STALL_CYCLES > 0) ? $clog2(MAX_STALL_CYCLES + 1) : 1;
    localparam logic [31:0] LAST_BEAT = 32'(EXPECTED_BEATS) - 32'd1;

    typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;

    state_t                state;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_next;
    logic [SW-1:0]         stall_len;
    logic [SW-1:0]         stall_cnt;
    logic [DATA_WIDTH-1:0] expected;
    logic                  hs;
    logic                  done_hit;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign stall_len = SW'(32'(lfsr) % (MAX_STALL_CYCLES + 1));
    assign hs        = axis_s_tvalid && axis_s_tready;
    assign done_hit  = (EXPECTED_BEATS != 0) && (beat_count_o == LAST_BEAT);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state             <= IDLE;
            axis_s_tready     <= 1'b0;
            lfsr              <= LFSR_SEED;
            stall_cnt         <= '0;
            expected          <= START_VALUE;
            beat_count_o      <= '0;
            error_count_o     <= '0;
            error_o           <= 1'b0;
            first_err_data_o  <= '0;
            first_err_index_o <= '0;
            done_o            <= 1'b0;
        end else begin
            // Expected advances on every beat so one corrupted beat costs exactly one error
            if (hs) begin
                lfsr     <= lfsr_next;
                expected <= expected + DATA_WIDTH'(1);
                if (beat_count_o != '1)
                    beat_count_o <= beat_count_o + 32'd1;
                if (axis_s_tdata != expected) begin
                    if (error_count_o != '1)
                        error_count_o <= error_count_o + 16'd1;
                    if (!error_o) begin
                        error_o           <= 1'b1;
                        first_err_data_o  <= axis_s_tdata;
                        first_err_index_o <= beat_count_o;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state         <= RUN;
                        axis_s_tready <= 1'b1;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (done_hit) begin
                            state         <= DONE;
                            axis_s_tready <= 1'b0;
                            done_o        <= 1'b1;
                        end else if (stall_len != '0) begin
                            state         <= STALL;
                            stall_cnt     <= stall_len;
                            axis_s_tready <= 1'b0;
                        end
                    end else if (!enable_i) begin
                        state         <= IDLE;
                        axis_s_tready <= 1'b0;
                    end
                end
                STALL: begin
                    // Leaving on a count of 1 keeps tready low for exactly stall_len cycles
                    if (stall_cnt == SW'(1)) begin
                        state         <= enable_i ? RUN : IDLE;
                        axis_s_tready <= enable_i;
                    end else begin
                        stall_cnt <= stall_cnt - SW'(1);
                    end
                end
                DONE: begin
                    axis_s_tready <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    axis_s_tready <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    logic                  pend;
    logic [DATA_WIDTH-1:0] pend_data;

    // A master that has offered a beat must hold it, unchanged, until it is taken
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pend      <= 1'b0;
            pend_data <= '0;
        end else begin
            if (pend && (!axis_s_tvalid || axis_s_tdata != pend_data))
                $error("AXIS master dropped/changed data before handshake");
            pend      <= axis_s_tvalid && !axis_s_tready;
            pend_data <= axis_s_tdata;
        end
    end
`endif

endmodule

// File: tb/tb_sim_axis_throttled_sink.sv
// Bench for sim_axis_throttled_sink: three instances (always-ready, random stall, 8-bit wrap with
// a beat limit) driven by a holding source, with per-beat expectations queued as beats are offered.
module tb_sim_axis_throttled_sink;

    localparam int N = 3;

    typedef struct {
        logic [31:0] beats;
        logic [15:0] errs;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  [N];
    logic        tv  [N];
    logic        tr  [N];
    logic [31:0] td  [N];
    logic [31:0] bc  [N];
    logic [15:0] ec  [N];
    logic        er  [N];
    logic        dn  [N];
    logic [31:0] fed [N];
    logic [31:0] fei [N];
    logic [7:0]  td8;
    logic [7:0]  fed8;

    int total = 0;
    int bad   = 0;

    exp_t        exp_q[$];
    int          stall_q[$];
    logic        trace[$];
    logic        trace_a[$];
    logic [31:0] sb_expv;
    int          sb_errs;
    int          sb_n;

    always #5 clk = ~clk;

    assign td8    = td[2][7:0];
    assign fed[2] = {24'd0, fed8};

    sim_axis_throttled_sink #(.MAX_STALL_CYCLES(0)) u_fast (
        .clock_i(clk), .reset_i(rst), .axis_s_tdata(td[0]), .axis_s_tvalid(tv[0]),
        .axis_s_tready(tr[0]), .enable_i(en[0]), .beat_count_o(bc[0]), .error_count_o(ec[0]),
        .error_o(er[0]), .first_err_data_o(fed[0]), .first_err_index_o(fei[0]), .done_o(dn[0]));

    sim_axis_throttled_sink u_rand (
        .clock_i(clk), .reset_i(rst), .axis_s_tdata(td[1]), .axis_s_tvalid(tv[1]),
        .axis_s_tready(tr[1]), .enable_i(en[1]), .beat_count_o(bc[1]), .error_count_o(ec[1]),
        .error_o(er[1]), .first_err_data_o(fed[1]), .first_err_index_o(fei[1]), .done_o(dn[1]));

    sim_axis_throttled_sink #(.DATA_WIDTH(8), .MAX_STALL_CYCLES(0), .START_VALUE(8'hFE),
                              .EXPECTED_BEATS(5)) u_narrow (
        .clock_i(clk), .reset_i(rst), .axis_s_tdata(td8), .axis_s_tvalid(tv[2]),
        .axis_s_tready(tr[2]), .enable_i(en[2]), .beat_count_o(bc[2]), .error_count_o(ec[2]),
        .error_o(er[2]), .first_err_data_o(fed8), .first_err_index_o(fei[2]), .done_o(dn[2]));

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0;
            tv[i] = 1'b0;
            td[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [31:0] mask, input int eb);
        exp_t e;
        if (((d ^ sb_expv) & mask) != 0) sb_errs++;
        sb_n++;
        e.beats = 32'(sb_n);
        e.errs  = 16'(sb_errs);
        e.done  = (eb != 0) && (sb_n == eb);
        exp_q.push_back(e);
        sb_expv = (sb_expv + 32'd1) & mask;
    endtask

    // Offers beats with tvalid held high; a handshake on the last posedge is known at this negedge
    // from the tready seen at the previous negedge.
    task automatic stream(input int id, input logic [31:0] beats[$], input logic [31:0] start,
                          input logic [31:0] mask, input int ms, input int eb, output int cyc);
        int          k      = 0;
        int          low    = 0;
        int          budget = 20 * beats.size() + 50;
        logic [15:0] lf     = 16'hACE1;
        logic        rp;
        exp_t        e;
        int          s;
        cyc     = 0;
        sb_expv = start;
        sb_errs = 0;
        sb_n    = 0;
        exp_q.delete();
        stall_q.delete();
        trace.delete();
        en[id] = 1'b1;
        tv[id] = 1'b1;
        td[id] = beats[0];
        push_exp(beats[0], mask, eb);
        rp = tr[id];
        while (k < beats.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rp) begin
                e = exp_q.pop_front();
                total++;
                if (bc[id] !== e.beats || ec[id] !== e.errs || dn[id] !== e.done) begin
                    bad++;
                    $display("FAIL beat[%0d] dut%0d: got cnt=%0d err=%0d done=%0b want cnt=%0d err=%0d done=%0b",
                             k, id, bc[id], ec[id], dn[id], e.beats, e.errs, e.done);
                end
                if (k > 0) begin
                    s = stall_q.pop_front();
                    total++;
                    if (low !== s) begin
                        bad++;
                        $display("FAIL stall[%0d] dut%0d: got %0d low cycles want %0d", k, id, low, s);
                    end
                end
                stall_q.push_back(int'(lf % 16'(ms + 1)));
                lf  = lfsr_step(lf);
                low = 0;
                k++;
                if (k < beats.size()) begin
                    td[id] = beats[k];
                    push_exp(beats[k], mask, eb);
                end else begin
                    tv[id] = 1'b0;
                end
            end
            if (!tr[id]) low++;
            trace.push_back(tr[id]);
            rp = tr[id];
        end
        if (k < beats.size()) begin
            total++;
            bad++;
            $display("FAIL stream timeout dut%0d: got %0d beats want %0d", id, k, beats.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            total++;
            if (tr[i] !== 1'b0 || bc[i] !== '0 || ec[i] !== '0 || er[i] !== 1'b0 ||
                dn[i] !== 1'b0 || fed[i] !== '0 || fei[i] !== '0) begin
                bad++;
                $display("FAIL reset dut%0d: got rdy=%0b cnt=%0d err=%0d e=%0b d=%0b fd=%0h fi=%0d want all 0",
                         i, tr[i], bc[i], ec[i], er[i], dn[i], fed[i], fei[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b[$];
        int          cyc;
        do_reset();
        for (int i = 0; i < 10; i++) b.push_back(32'(i));
        stream(0, b, 32'd0, 32'hFFFF_FFFF, 0, 0, cyc);
        total++;
        if (cyc !== 11) begin
            bad++;
            $display("FAIL b2b cycles: got %0d want 11", cyc);
        end
        total++;
        if (trace.size() < 1 || trace[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b ready after enable: got %0b want 1", trace.size() > 0 ? trace[0] : 1'bx);
        end
        total++;
        if (bc[0] !== 32'd10 || er[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b totals: got cnt=%0d err=%0b want cnt=10 err=0", bc[0], er[0]);
        end
    endtask

    task automatic test_error();
        logic [31:0] b[$];
        int          cyc;
        do_reset();
        b = '{32'd0, 32'd1, 32'd2, 32'd7, 32'd4, 32'd5};
        stream(0, b, 32'd0, 32'hFFFF_FFFF, 0, 0, cyc);
        total++;
        if (ec[0] !== 16'd1 || er[0] !== 1'b1 || fed[0] !== 32'd7 || fei[0] !== 32'd3) begin
            bad++;
            $display("FAIL first error: got cnt=%0d e=%0b data=%0d idx=%0d want cnt=1 e=1 data=7 idx=3",
                     ec[0], er[0], fed[0], fei[0]);
        end
    endtask

    task automatic test_random_stall();
        logic [31:0] b[$];
        int          cyc;
        int          run  = 0;
        int          mrun = 0;
        int          diffs = 0;
        do_reset();
        for (int i = 0; i < 100; i++) b.push_back(32'(i));
        stream(1, b, 32'd0, 32'hFFFF_FFFF, 6, 0, cyc);
        total++;
        if (bc[1] !== 32'd100 || ec[1] !== 16'd0) begin
            bad++;
            $display("FAIL stall totals: got cnt=%0d err=%0d want cnt=100 err=0", bc[1], ec[1]);
        end
        for (int i = 1; i < trace.size(); i++) begin
            run = trace[i] ? 0 : run + 1;
            if (run > mrun) mrun = run;
        end
        total++;
        if (mrun > 6) begin
            bad++;
            $display("FAIL stall bound: got %0d low cycles want <= 6", mrun);
        end
        trace_a = trace;
        do_reset();
        stream(1, b, 32'd0, 32'hFFFF_FFFF, 6, 0, cyc);
        for (int i = 0; i < trace_a.size(); i++)
            if (i >= trace.size() || trace[i] !== trace_a[i]) diffs++;
        total++;
        if (diffs != 0 || trace.size() != trace_a.size()) begin
            bad++;
            $display("FAIL rerun trace: got %0d differing cycles len %0d want 0 differing len %0d",
                     diffs, trace.size(), trace_a.size());
        end
    endtask

    task automatic test_reset_in_stall();
        logic [31:0] b[$];
        int          cyc;
        int          nb = 0;
        logic        rp;
        logic        found = 1'b0;
        do_reset();
        en[1] = 1'b1;
        tv[1] = 1'b1;
        td[1] = 32'd0;
        rp    = tr[1];
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (rp) begin
                nb++;
                td[1] = 32'(nb);
                if (!tr[1]) found = 1'b1;
            end
            rp = tr[1];
        end
        total++;
        if (!found || bc[1] !== 32'(nb)) begin
            bad++;
            $display("FAIL reach stall: got found=%0b cnt=%0d want found=1 cnt=%0d", found, bc[1], nb);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (tr[1] !== 1'b0 || bc[1] !== '0 || ec[1] !== '0 || er[1] !== 1'b0 || dn[1] !== 1'b0) begin
            bad++;
            $display("FAIL reset in stall: got rdy=%0b cnt=%0d err=%0d e=%0b d=%0b want all 0",
                     tr[1], bc[1], ec[1], er[1], dn[1]);
        end
        td[1] = 32'd0;
        rst   = 1'b0;
        en[1] = 1'b1;
        @(negedge clk);
        total++;
        if (tr[1] !== 1'b1) begin
            bad++;
            $display("FAIL ready after reset: got %0b want 1", tr[1]);
        end
        for (int i = 0; i < 12; i++) b.push_back(32'(i));
        stream(1, b, 32'd0, 32'hFFFF_FFFF, 6, 0, cyc);
    endtask

    task automatic test_wrap_done();
        logic [31:0] b[$];
        int          cyc;
        do_reset();
        b = '{32'hFE, 32'hFF, 32'h00, 32'h01, 32'h02};
        stream(2, b, 32'hFE, 32'hFF, 0, 5, cyc);
        total++;
        if (ec[2] !== 16'd0 || er[2] !== 1'b0) begin
            bad++;
            $display("FAIL wrap: got err=%0d e=%0b want err=0 e=0", ec[2], er[2]);
        end
        tv[2] = 1'b1;
        td[2] = 32'h03;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (tr[2] !== 1'b0 || bc[2] !== 32'd5 || dn[2] !== 1'b1) begin
                bad++;
                $display("FAIL done hold[%0d]: got rdy=%0b cnt=%0d done=%0b want rdy=0 cnt=5 done=1",
                         i, tr[2], bc[2], dn[2]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0;
            tv[i] = 1'b0;
            td[i] = '0;
        end
        test_reset();
        test_back_to_back();
        test_error();
        test_random_stall();
        test_reset_in_stall();
        test_wrap_done();
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
